// File: rtl/ov7670_frame_capture_pkg.sv
// Shared types and default geometry for the OV7670 frame capture front end.
package ov7670_cap_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2,
    DONE   = 2'd3
  } cap_state_t;

  typedef logic [15:0] rgb565_t;

  localparam int DEF_H_PIXELS = 320;
  localparam int DEF_V_LINES  = 240;
  localparam int DEF_ADDR_W   = 17;
  localparam int DEF_DONE_LEN = 4;

endpackage

// File: rtl/ov7670_frame_capture_if.sv
// Frame-buffer write port: one strobe, linear pixel address and RGB565 data.
interface ov7670_frame_capture_if #(
  parameter int ADDR_W = 17
);
  import ov7670_cap_pkg::*;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  rgb565_t           wr_data;

  modport master (output wr_en, wr_addr, wr_data);
  modport slave  (input  wr_en, wr_addr, wr_data);

endinterface

// File: rtl/ov7670_byte_pair.sv
// Pairs registered sensor bytes into RGB565 pixels. The first byte of each
// pair is the high byte. odd_byte flags a line that closed mid-pair.
module ov7670_byte_pair
  import ov7670_cap_pkg::*;
(
  input  logic       pclk,
  input  logic       irst_n,
  input  logic       active,
  input  logic       hr_q,
  input  logic       hr_fall,
  input  logic [7:0] d_q,
  output logic       pixel_valid,
  output rgb565_t    pixel,
  output logic       odd_byte
);

  logic       phase_reg, phase_next;
  logic [7:0] hi_reg, hi_next;

  // Phase toggles per active byte; it is forced to 0 at line end and outside capture.
  always_comb begin
    phase_next = phase_reg;
    hi_next    = hi_reg;
    if (!active || hr_fall) begin
      phase_next = 1'b0;
    end else if (hr_q) begin
      phase_next = ~phase_reg;
      if (!phase_reg) hi_next = d_q;
    end
  end

  // Phase and high-byte holding registers.
  always_ff @(posedge pclk or negedge irst_n) begin
    if (!irst_n) begin
      phase_reg <= 1'b0;
      hi_reg    <= 8'h00;
    end else begin
      phase_reg <= phase_next;
      hi_reg    <= hi_next;
    end
  end

  assign pixel_valid = active & hr_q & phase_reg;
  assign pixel       = {hi_reg, d_q};
  assign odd_byte    = active & hr_fall & phase_reg;

endmodule

// File: rtl/ov7670_frame_capture.sv
// OV7670 capture top: input registering, frame FSM, geometry checks and
// linear frame-buffer addressing. Optional macro FRAME_CAPTURE_STATS_EN adds
// good_frames / bad_frames counters.
module ov7670_frame_capture
  import ov7670_cap_pkg::*;
#(
  parameter int H_PIXELS = DEF_H_PIXELS,
  parameter int V_LINES  = DEF_V_LINES,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DONE_LEN = DEF_DONE_LEN
) (
  input  logic                   pclk,
  input  logic                   irst_n,
  input  logic                   vsync,
  input  logic                   href,
  input  logic [7:0]             din,
  input  logic                   capture_en,
  ov7670_frame_capture_if.master fb,
  output logic                   frame_done,
  output logic                   frame_err,
  output logic                   busy
`ifdef FRAME_CAPTURE_STATS_EN
  ,
  output logic [15:0]            good_frames,
  output logic [15:0]            bad_frames
`endif
);

  localparam int PIX_W  = $clog2(H_PIXELS + 1);
  localparam int LINE_W = $clog2(V_LINES + 2);
  localparam int DONE_W = (DONE_LEN > 1) ? $clog2(DONE_LEN) : 1;

  localparam logic [PIX_W-1:0]  H_CNT     = PIX_W'(H_PIXELS);
  localparam logic [LINE_W-1:0] V_CNT     = LINE_W'(V_LINES);
  localparam logic [LINE_W-1:0] V_SAT     = LINE_W'(V_LINES + 1);
  localparam logic [DONE_W-1:0] DONE_LAST = DONE_W'(DONE_LEN - 1);

  logic       vs_q, vs_qq, hr_q, hr_qq;
  logic [7:0] d_q;
  logic       vs_rise, vs_fall, hr_fall;

  cap_state_t        state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [PIX_W-1:0]  pix_reg, pix_next;
  logic [LINE_W-1:0] line_reg, line_next;
  logic              bad_reg, bad_next;
  logic [DONE_W-1:0] done_cnt_reg, done_cnt_next;

  logic              wr_en_reg, wr_en_next;
  logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
  rgb565_t           wr_data_reg, wr_data_next;
  logic              frame_done_reg, frame_done_next;
  logic              frame_err_reg, frame_err_next;

  logic    pixel_valid, odd_byte;
  rgb565_t pixel;

  // Register the camera pins once and keep a second copy for edge detection.
  always_ff @(posedge pclk or negedge irst_n) begin
    if (!irst_n) begin
      vs_q  <= 1'b0;
      vs_qq <= 1'b0;
      hr_q  <= 1'b0;
      hr_qq <= 1'b0;
      d_q   <= 8'h00;
    end else begin
      vs_q  <= vsync;
      vs_qq <= vs_q;
      hr_q  <= href;
      hr_qq <= hr_q;
      d_q   <= din;
    end
  end

  assign vs_rise = vs_q & ~vs_qq;
  assign vs_fall = ~vs_q & vs_qq;
  assign hr_fall = ~hr_q & hr_qq;

  ov7670_byte_pair u_byte_pair (
    .pclk        (pclk),
    .irst_n      (irst_n),
    .active      (state_reg == ACTIVE),
    .hr_q        (hr_q),
    .hr_fall     (hr_fall),
    .d_q         (d_q),
    .pixel_valid (pixel_valid),
    .pixel       (pixel),
    .odd_byte    (odd_byte)
  );

  // Next-state, counter and output decode; the line close is evaluated before
  // the frame check so a same-cycle vsync rise sees the updated line count.
  always_comb begin
    state_next      = state_reg;
    addr_next       = addr_reg;
    pix_next        = pix_reg;
    line_next       = line_reg;
    bad_next        = bad_reg;
    done_cnt_next   = done_cnt_reg;
    wr_en_next      = 1'b0;
    wr_addr_next    = wr_addr_reg;
    wr_data_next    = wr_data_reg;
    frame_done_next = 1'b0;
    frame_err_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (capture_en) state_next = SYNC;
      end
      SYNC: begin
        if (vs_fall) begin
          addr_next  = '0;
          pix_next   = '0;
          line_next  = '0;
          bad_next   = 1'b0;
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        if (pixel_valid) begin
          // A pixel landing on the closing vsync edge cannot belong to a good frame.
          if (pix_reg < H_CNT && line_reg < V_CNT && !vs_rise) begin
            wr_en_next   = 1'b1;
            wr_addr_next = addr_reg;
            wr_data_next = pixel;
            addr_next    = addr_reg + ADDR_W'(1);
            pix_next     = pix_reg + PIX_W'(1);
          end else begin
            bad_next = 1'b1;
          end
        end
        if (hr_fall) begin
          if (pix_reg != H_CNT || odd_byte) bad_next = 1'b1;
          if (line_reg != V_SAT) line_next = line_reg + LINE_W'(1);
          pix_next = '0;
        end
        if (vs_rise) begin
          if (line_next == V_CNT && !bad_next) begin
            state_next      = DONE;
            done_cnt_next   = '0;
            frame_done_next = 1'b1;
          end else begin
            frame_err_next = 1'b1;
            state_next     = capture_en ? SYNC : IDLE;
          end
        end
      end
      DONE: begin
        if (done_cnt_reg == DONE_LAST) begin
          state_next = capture_en ? SYNC : IDLE;
        end else begin
          done_cnt_next   = done_cnt_reg + DONE_W'(1);
          frame_done_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge pclk or negedge irst_n) begin
    if (!irst_n) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      pix_reg        <= '0;
      line_reg       <= '0;
      bad_reg        <= 1'b0;
      done_cnt_reg   <= '0;
      wr_en_reg      <= 1'b0;
      wr_addr_reg    <= '0;
      wr_data_reg    <= '0;
      frame_done_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      addr_reg       <= addr_next;
      pix_reg        <= pix_next;
      line_reg       <= line_next;
      bad_reg        <= bad_next;
      done_cnt_reg   <= done_cnt_next;
      wr_en_reg      <= wr_en_next;
      wr_addr_reg    <= wr_addr_next;
      wr_data_reg    <= wr_data_next;
      frame_done_reg <= frame_done_next;
      frame_err_reg  <= frame_err_next;
    end
  end

  assign fb.wr_en    = wr_en_reg;
  assign fb.wr_addr  = wr_addr_reg;
  assign fb.wr_data  = wr_data_reg;
  assign frame_done = frame_done_reg;
  assign frame_err  = frame_err_reg;
  assign busy       = (state_reg != IDLE);

`ifdef FRAME_CAPTURE_STATS_EN
  logic [15:0] good_reg, bad_cnt_reg;

  // Good frames wrap; bad frames saturate so a long error burst stays visible.
  always_ff @(posedge pclk or negedge irst_n) begin
    if (!irst_n) begin
      good_reg    <= 16'h0000;
      bad_cnt_reg <= 16'h0000;
    end else begin
      if (state_reg == ACTIVE && state_next == DONE) good_reg <= good_reg + 16'd1;
      if (frame_err_next && bad_cnt_reg != 16'hFFFF) bad_cnt_reg <= bad_cnt_reg + 16'd1;
    end
  end

  assign good_frames = good_reg;
  assign bad_frames  = bad_cnt_reg;
`endif

endmodule

// File: tb/tb_ov7670_frame_capture.sv
// Self-checking bench for ov7670_frame_capture on a reduced 8x6 geometry.
// Reference model: per frame, writes are the byte pairs of each line with
// pixel index < H and line index < V at a running address; a frame is good
// only with exactly V lines of exactly 2H bytes.
`timescale 1ns/1ps
module tb_ov7670_frame_capture;

  localparam int H  = 8;
  localparam int V  = 6;
  localparam int AW = 6;
  localparam int DL = 4;

  logic       pclk = 1'b0;
  logic       irst_n = 1'b0;
  logic       vsync = 1'b1;
  logic       href = 1'b0;
  logic [7:0] din = 8'h00;
  logic       capture_en = 1'b0;
  logic       frame_done, frame_err, busy;
`ifdef FRAME_CAPTURE_STATS_EN
  logic [15:0] good_frames, bad_frames;
`endif

  ov7670_frame_capture_if #(.ADDR_W(AW)) fb_if ();

  ov7670_frame_capture #(
    .H_PIXELS (H),
    .V_LINES  (V),
    .ADDR_W   (AW),
    .DONE_LEN (DL)
  ) dut (
    .pclk        (pclk),
    .irst_n      (irst_n),
    .vsync       (vsync),
    .href        (href),
    .din         (din),
    .capture_en  (capture_en),
    .fb          (fb_if),
    .frame_done  (frame_done),
    .frame_err   (frame_err),
    .busy        (busy)
`ifdef FRAME_CAPTURE_STATS_EN
    ,
    .good_frames (good_frames),
    .bad_frames  (bad_frames)
`endif
  );

  always #5 pclk = ~pclk;

  typedef logic [AW+15:0] wr_t;

  wr_t got_q[$];
  int  done_w_q[$];
  int  err_w_q[$];
  int  done_run = 0;
  int  err_run = 0;
  int  vectors = 0;
  int  miscompares = 0;

  int  line_len [16];
  int  n_lines;
  bit  same_edge;
  int  en_line = -1;
  bit  en_val;

  // Passive monitor: logs writes and pulse widths away from the active edge.
  always @(negedge pclk) begin
    if (fb_if.wr_en) got_q.push_back({fb_if.wr_addr, fb_if.wr_data});
    if (frame_done) done_run++;
    else if (done_run > 0) begin done_w_q.push_back(done_run); done_run = 0; end
    if (frame_err) err_run++;
    else if (err_run > 0) begin err_w_q.push_back(err_run); err_run = 0; end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_geom();
    n_lines   = V;
    same_edge = 1'b0;
    for (int i = 0; i < 16; i++) line_len[i] = 2 * H;
  endtask

  task automatic do_reset();
    irst_n = 1'b0;
    repeat (2) @(negedge pclk);
    irst_n = 1'b1;
    repeat (4) @(negedge pclk);
  endtask

  // Drive one frame (vsync fall .. vsync rise + blanking) and check it against the model.
  task automatic send_frame(input bit expect_cap, input bit pattern);
    wr_t        exp_q[$];
    logic [7:0] lb[$];
    int addr, lat_d, lat_e, gb, db, eb, n_done, n_err, n;
    bit good;
    gb = got_q.size(); db = done_w_q.size(); eb = err_w_q.size();
    addr = 0; lat_d = 0; lat_e = 0;
    good = (n_lines == V);
    vsync = 1'b0;
    repeat (3) @(negedge pclk);
    for (int l = 0; l < n_lines; l++) begin
      if (l == en_line) capture_en = en_val;
      if (line_len[l] != 2 * H) good = 1'b0;
      lb.delete();
      for (int k = 0; k < line_len[l]; k++)
        lb.push_back(pattern ? ((k % 2 == 1) ? 8'h05 : 8'hA0) : 8'($urandom));
      for (int p = 0; 2 * p + 1 < line_len[l]; p++)
        if (expect_cap && p < H && l < V) begin
          exp_q.push_back({AW'(addr), lb[2*p], lb[2*p+1]});
          addr++;
        end
      for (int k = 0; k < line_len[l]; k++) begin
        href = 1'b1; din = lb[k];
        @(negedge pclk);
      end
      href = 1'b0; din = 8'($urandom);
      if (!(same_edge && l == n_lines - 1)) repeat (4) @(negedge pclk);
    end
    vsync = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge pclk);
      if (frame_done && lat_d == 0) lat_d = i + 1;
      if (frame_err && lat_e == 0) lat_e = i + 1;
    end
    n_done = (expect_cap && good) ? 1 : 0;
    n_err  = (expect_cap && !good) ? 1 : 0;
    vectors++;
    if (done_w_q.size() - db !== n_done) begin
      miscompares++;
      $display("FAIL done_count: got %0d pulses, expected %0d", done_w_q.size() - db, n_done);
    end
    if (n_done == 1 && done_w_q.size() > db) begin
      vectors++;
      if (done_w_q[db] !== DL) begin
        miscompares++;
        $display("FAIL done_width: got %0d cycles, expected %0d", done_w_q[db], DL);
      end
      vectors++;
      if (lat_d !== 2) begin
        miscompares++;
        $display("FAIL done_latency: got %0d, expected 2", lat_d);
      end
    end
    vectors++;
    if (err_w_q.size() - eb !== n_err) begin
      miscompares++;
      $display("FAIL err_count: got %0d pulses, expected %0d", err_w_q.size() - eb, n_err);
    end
    if (n_err == 1 && err_w_q.size() > eb) begin
      vectors++;
      if (err_w_q[eb] !== 1) begin
        miscompares++;
        $display("FAIL err_width: got %0d cycles, expected 1", err_w_q[eb]);
      end
      vectors++;
      if (lat_e !== 2) begin
        miscompares++;
        $display("FAIL err_latency: got %0d, expected 2", lat_e);
      end
    end
    n = got_q.size() - gb;
    vectors++;
    if (n !== exp_q.size()) begin
      miscompares++;
      $display("FAIL write_count: got %0d writes, expected %0d", n, exp_q.size());
    end
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      vectors++;
      if (got_q[gb+i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL write_%0d: got addr %0d data %h, expected addr %0d data %h", i,
                 got_q[gb+i][AW+15:16], got_q[gb+i][15:0], exp_q[i][AW+15:16], exp_q[i][15:0]);
        break;
      end
    end
    $display("frame: lines=%0d good=%0b cap=%0b writes=%0d/%0d done=%0d err=%0d",
             n_lines, good, expect_cap, n, exp_q.size(), done_w_q.size() - db, err_w_q.size() - eb);
  endtask

  task automatic test_reset();
    irst_n = 1'b0; capture_en = 1'b0; vsync = 1'b1;
    repeat (3) @(negedge pclk);
    vectors++; if (fb_if.wr_en !== 1'b0) begin miscompares++; $display("FAIL rst_wr_en: got %b, expected 0", fb_if.wr_en); end
    vectors++; if (fb_if.wr_addr !== '0) begin miscompares++; $display("FAIL rst_wr_addr: got %0d, expected 0", fb_if.wr_addr); end
    vectors++; if (fb_if.wr_data !== 16'h0) begin miscompares++; $display("FAIL rst_wr_data: got %h, expected 0", fb_if.wr_data); end
    vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL rst_frame_done: got %b, expected 0", frame_done); end
    vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL rst_frame_err: got %b, expected 0", frame_err); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b, expected 0", busy); end
    irst_n = 1'b1;
    repeat (2) @(negedge pclk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b, expected 0", busy); end
    capture_en = 1'b1;
    repeat (2) @(negedge pclk);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL armed_busy: got %b, expected 1", busy); end
`ifdef FRAME_CAPTURE_STATS_EN
    vectors++; if (good_frames !== 16'd0 || bad_frames !== 16'd0) begin
      miscompares++; $display("FAIL rst_stats: got %0d/%0d, expected 0/0", good_frames, bad_frames);
    end
`endif
    $display("reset: checked");
  endtask

  task automatic test_full_frame();
    set_geom();
    send_frame(1'b1, 1'b1);
    set_geom(); same_edge = 1'b1;
    send_frame(1'b1, 1'b0);
  endtask

  task automatic test_mid_arm();
    capture_en = 1'b0;
    do_reset();
    set_geom(); en_line = 2; en_val = 1'b1;
    send_frame(1'b0, 1'b0);
    en_line = -1;
    send_frame(1'b1, 1'b0);
  endtask

  task automatic test_short_line();
    set_geom(); line_len[3] = 2 * H - 2;
    send_frame(1'b1, 1'b0);
    set_geom();
    send_frame(1'b1, 1'b0);
  endtask

  task automatic test_odd_line();
    set_geom(); line_len[2] = 2 * H + 1;
    send_frame(1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    int gb;
    capture_en = 1'b1;
    vsync = 1'b0;
    repeat (3) @(negedge pclk);
    for (int l = 0; l < V; l++) begin
      for (int k = 0; k < 2 * H; k++) begin
        href = 1'b1; din = 8'($urandom);
        @(negedge pclk);
        if (l == 3 && k == 5) begin
          irst_n = 1'b0;
          #1;
          vectors++; if (fb_if.wr_en !== 1'b0) begin miscompares++; $display("FAIL arst_wr_en: got %b, expected 0", fb_if.wr_en); end
          vectors++; if (fb_if.wr_addr !== '0) begin miscompares++; $display("FAIL arst_wr_addr: got %0d, expected 0", fb_if.wr_addr); end
          vectors++; if (fb_if.wr_data !== 16'h0) begin miscompares++; $display("FAIL arst_wr_data: got %h, expected 0", fb_if.wr_data); end
          vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL arst_busy: got %b, expected 0", busy); end
          vectors++; if (frame_done !== 1'b0 || frame_err !== 1'b0) begin
            miscompares++; $display("FAIL arst_pulses: got %b%b, expected 00", frame_done, frame_err);
          end
        end
        if (l == 3 && k == 7) irst_n = 1'b1;
      end
      href = 1'b0;
      repeat (4) @(negedge pclk);
    end
    gb = got_q.size();
    vsync = 1'b1;
    repeat (12) @(negedge pclk);
    vectors++;
    if (got_q.size() !== gb) begin
      miscompares++; $display("FAIL post_reset_writes: got %0d, expected 0", got_q.size() - gb);
    end
    $display("reset mid-frame: checked");
    set_geom();
    send_frame(1'b1, 1'b0);
  endtask

  task automatic test_en_drop();
    set_geom(); en_line = 3; en_val = 1'b0;
    send_frame(1'b1, 1'b0);
    en_line = -1;
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL en_drop_busy: got %b, expected 0", busy); end
    capture_en = 1'b1;
    repeat (2) @(negedge pclk);
  endtask

  task automatic test_random();
    int r;
    for (int f = 0; f < 6; f++) begin
      set_geom();
      r = $urandom_range(0, 4);
      n_lines = (r == 0) ? V - 1 : ((r == 4) ? V + 1 : V);
      for (int l = 0; l < n_lines; l++) begin
        r = $urandom_range(0, 9);
        line_len[l] = (r == 0) ? 2*H - 2 : (r == 1) ? 2*H + 1 : (r == 2) ? 2*H + 2 : 2*H;
      end
      same_edge = 1'($urandom_range(0, 1));
      send_frame(1'b1, 1'b0);
    end
  endtask

`ifdef FRAME_CAPTURE_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int f = 0; f < 3; f++) begin set_geom(); send_frame(1'b1, 1'b0); end
    set_geom(); line_len[1] = 2 * H - 2;
    send_frame(1'b1, 1'b0);
    vectors++;
    if (good_frames !== 16'd3) begin miscompares++; $display("FAIL good_frames: got %0d, expected 3", good_frames); end
    vectors++;
    if (bad_frames !== 16'd1) begin miscompares++; $display("FAIL bad_frames: got %0d, expected 1", bad_frames); end
  endtask
`endif

  initial begin
    test_reset();
    test_full_frame();
    test_mid_arm();
    test_short_line();
    test_odd_line();
    test_reset_mid();
    test_en_drop();
    test_random();
`ifdef FRAME_CAPTURE_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
